// File: rtl/lzrw1_pkg.sv
// lzrw1_pkg: shared types and constants for the LZRW1 item packer.
package lzrw1_pkg;

   // Items per group; one 16-bit control word covers one group.
   localparam int GROUP_ITEMS = 16;
   localparam int CTRL_W      = 16;

   // Copy-item field widths.
   localparam int OFFSET_W = 12;
   localparam int LEN_W    = 4;

   // Packer phases: gather items, then stream control word and body.
   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      CTRL_LO = 2'd1,
      CTRL_HI = 2'd2,
      BODY    = 2'd3
   } state_t;

   // A copy is malformed when its length code is below 2 or its distance is zero.
   function automatic logic is_illegal_copy(input logic [OFFSET_W-1:0] offset,
                                            input logic [LEN_W-1:0]    length);
      return (length < LEN_W'(2)) || (offset == '0);
   endfunction

endpackage

// File: rtl/lzrw1_item_buf.sv
// lzrw1_item_buf: byte FIFO for one group's item bytes; writes one or two
// bytes per cycle, reads one byte per cycle, cleared between groups.
module lzrw1_item_buf #(
   parameter int BUF_BYTES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       wr_en,
   input  logic       wr_two,
   input  logic [7:0] wr_byte0,
   input  logic [7:0] wr_byte1,
   input  logic       rd_en,
   output logic [7:0] rd_byte,
   output logic       rd_is_last
);

   localparam int AW = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
   localparam int CW = $clog2(BUF_BYTES + 1);

   logic [7:0]    mem [BUF_BYTES];
   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] rd_ptr;
   logic [AW-1:0] wr_addr0;
   logic [AW-1:0] wr_addr1;

   assign wr_addr0 = wr_ptr[AW-1:0];
   assign wr_addr1 = wr_ptr[AW-1:0] + AW'(1);

   // Pointer update: advance on write/read, rewind at group end or reset.
   // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (wr_two ? CW'(2) : CW'(1));
         if (rd_en) rd_ptr <= rd_ptr + CW'(1);
      end
   end

   // Byte storage: one or two bytes land at the write pointer.
   // NOTE: the byte array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr0] <= wr_byte0;
         if (wr_two) mem[wr_addr1] <= wr_byte1;
      end
   end

   assign rd_byte    = mem[rd_ptr[AW-1:0]];
   assign rd_is_last = ((rd_ptr + CW'(1)) == wr_ptr);

endmodule

// File: rtl/lzrw1_item_packer.sv
// lzrw1_item_packer: packs literal/copy items into LZRW1 groups: a 16-bit
// control word (LSB first, bit k = item k is a copy) followed by item bytes.
module lzrw1_item_packer #(
   parameter int GROUP_ITEMS = lzrw1_pkg::GROUP_ITEMS,
   parameter int BUF_BYTES   = 2 * GROUP_ITEMS
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_is_copy,
   input  logic [7:0]                    in_literal,
   input  logic [lzrw1_pkg::OFFSET_W-1:0] in_offset,
   input  logic [lzrw1_pkg::LEN_W-1:0]    in_length,
   input  logic                          in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [7:0]                    out_byte,
   output logic                          out_last,
   output logic                          err
);

   import lzrw1_pkg::*;

   localparam int KW = $clog2(GROUP_ITEMS + 1);

   state_t            state;
   state_t            state_nxt;
   logic [KW-1:0]     k;
   logic [CTRL_W-1:0] ctrl;
   logic [CTRL_W-1:0] bit_mask;
   logic              close_last;
   logic              accept;
   logic              xfer;
   logic              group_close;
   logic              body_done;
   logic              rd_en;
   logic              rd_is_last;
   logic [7:0]        rd_byte;
   logic [7:0]        wr_byte0;

   assign in_ready    = (state == COLLECT);
   assign out_valid   = (state != COLLECT);
   assign accept      = in_valid & in_ready;
   assign xfer        = out_valid & out_ready;
   assign group_close = accept & ((k == KW'(GROUP_ITEMS - 1)) | in_last);
   assign rd_en       = (state == BODY) & xfer;
   assign body_done   = rd_en & rd_is_last;
   assign bit_mask    = CTRL_W'(1) << k;
   assign wr_byte0    = in_is_copy ? {in_offset[OFFSET_W-1:8], in_length} : in_literal;

   lzrw1_item_buf #(
      .BUF_BYTES (BUF_BYTES)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .clear      (body_done),
      .wr_en      (accept),
      .wr_two     (in_is_copy),
      .wr_byte0   (wr_byte0),
      .wr_byte1   (in_offset[7:0]),
      .rd_en      (rd_en),
      .rd_byte    (rd_byte),
      .rd_is_last (rd_is_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= COLLECT;
      else       state <= state_nxt;
   end

   // Group bookkeeping: item index, control bits and whether this group ends the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         k          <= '0;
         ctrl       <= '0;
         close_last <= 1'b0;
      end else if (accept) begin
         k    <= k + KW'(1);
         ctrl <= in_is_copy ? (ctrl | bit_mask) : (ctrl & ~bit_mask);
         if (group_close) close_last <= in_last;
      end else if (body_done) begin
         k          <= '0;
         ctrl       <= '0;
         close_last <= 1'b0;
      end
   end

   // Sticky flag for malformed copies; the item is still packed unchanged.
   always_ff @(posedge clk) begin
      if (reset)                                                        err <= 1'b0;
      else if (accept && in_is_copy && is_illegal_copy(in_offset, in_length)) err <= 1'b1;
   end

   // Next state and output byte selection; advances only on a byte transfer.
   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      out_byte  = 8'h00;
      out_last  = 1'b0;
      case (state)
         COLLECT: begin
            if (group_close) state_nxt = CTRL_LO;
         end
         CTRL_LO: begin
            out_byte = ctrl[7:0];
            if (xfer) state_nxt = CTRL_HI;
         end
         CTRL_HI: begin
            out_byte = ctrl[15:8];
            if (xfer) state_nxt = BODY;
         end
         BODY: begin
            out_byte = rd_byte;
            out_last = close_last & rd_is_last;
            if (body_done) state_nxt = COLLECT;
         end
         default: state_nxt = COLLECT;
      endcase
   end

endmodule

// File: tb/tb_lzrw1_item_packer.sv
// tb_lzrw1_item_packer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based group model.
module tb_lzrw1_item_packer;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_is_copy;
   logic [7:0]  in_literal;
   logic [11:0] in_offset;
   logic [3:0]  in_length;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_byte;
   logic        out_last;
   logic        err;

   lzrw1_item_packer dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_is_copy (in_is_copy),
      .in_literal (in_literal),
      .in_offset  (in_offset),
      .in_length  (in_length),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_byte   (out_byte),
      .out_last   (out_last),
      .err        (err)
   );

   typedef struct {
      logic [7:0] b;
      logic       last;
   } obyte_t;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state
   obyte_t     exp_q[$];
   obyte_t     got_q[$];
   logic [7:0] cur_bytes[$];
   logic [15:0] cur_ctrl = '0;
   int         cur_k = 0;
   logic       m_err = 1'b0;

   // Ready control
   int   ready_mode = 0;
   logic ready_script[$];

   // Directed expectations
   logic [7:0] e_b[$];
   logic       e_l[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: wait bound expired", name);
   endtask

   task automatic add_exp(input logic [7:0] b, input logic l);
      e_b.push_back(b);
      e_l.push_back(l);
   endtask

   task automatic check_got(input string name);
      check({name, " count"}, got_q.size(), e_b.size());
      for (int i = 0; i < e_b.size() && i < got_q.size(); i++) begin
         check($sformatf("%s byte%0d", name, i), {24'h0, got_q[i].b}, {24'h0, e_b[i]});
         check($sformatf("%s last%0d", name, i), {31'h0, got_q[i].last}, {31'h0, e_l[i]});
      end
      e_b.delete();
      e_l.delete();
      got_q.delete();
   endtask

   // Present one item and hold it until the packer takes it.
   task automatic send_item(input logic cp, input logic [7:0] lit, input logic [11:0] off,
                            input logic [3:0] len, input logic lst);
      int   waited = 0;
      logic taken  = 1'b0;
      in_valid   = 1'b1;
      in_is_copy = cp;
      in_literal = lit;
      in_offset  = off;
      in_length  = len;
      in_last    = lst;
      while (!taken && waited < 3000) begin
         @(negedge clk);
         taken = in_ready;
         waited++;
      end
      if (!taken) fail_now("send_item");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Wait until every expected byte has left and the output is idle.
   task automatic drain();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((exp_q.size() != 0 || out_valid) && n < 3000);
      if (n >= 3000) fail_now("drain");
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Downstream ready generator.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (reset)                      out_ready = 1'b0;
         else if (ready_script.size())   out_ready = ready_script.pop_front();
         else if (ready_mode == 0)       out_ready = 1'b1;
         else                            out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Per-cycle compare against the group model; checks first, then model update.
   initial begin
      obyte_t o;
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            cur_bytes.delete();
            cur_ctrl = '0;
            cur_k    = 0;
            m_err    = 1'b0;
         end else begin
            check("in_ready",  {31'h0, in_ready},  {31'h0, exp_q.size() == 0});
            check("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
            check("err",       {31'h0, err},       {31'h0, m_err});
            if (out_valid && exp_q.size() != 0) begin
               check("out_byte", {24'h0, out_byte}, {24'h0, exp_q[0].b});
               check("out_last", {31'h0, out_last}, {31'h0, exp_q[0].last});
            end
            if (out_valid && out_ready) begin
               o.b    = out_byte;
               o.last = out_last;
               got_q.push_back(o);
               if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (in_valid && in_ready) begin
               if (in_is_copy) begin
                  cur_ctrl[cur_k] = 1'b1;
                  cur_bytes.push_back({in_offset[11:8], in_length});
                  cur_bytes.push_back(in_offset[7:0]);
                  if (in_length < 2 || in_offset == 0) m_err = 1'b1;
               end else begin
                  cur_bytes.push_back(in_literal);
               end
               cur_k++;
               if (cur_k == 16 || in_last) begin
                  o.last = 1'b0;
                  o.b = cur_ctrl[7:0];  exp_q.push_back(o);
                  o.b = cur_ctrl[15:8]; exp_q.push_back(o);
                  for (int i = 0; i < cur_bytes.size(); i++) begin
                     o.b    = cur_bytes[i];
                     o.last = in_last && (i == cur_bytes.size() - 1);
                     exp_q.push_back(o);
                  end
                  cur_bytes.delete();
                  cur_ctrl = '0;
                  cur_k    = 0;
               end
            end
         end
      end
   end

   // Hard stop if something never terminates.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Main stimulus sequence.
   initial begin
      logic        cp;
      logic [7:0]  lit;
      logic [11:0] off;
      logic [3:0]  len;
      logic        lst;
      int          n;

      reset      = 1'b1;
      in_valid   = 1'b0;
      in_is_copy = 1'b0;
      in_literal = '0;
      in_offset  = '0;
      in_length  = '0;
      in_last    = 1'b0;
      idle(3);
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst in_ready",  {31'h0, in_ready},  32'd1);
      check("rst out_valid", {31'h0, out_valid}, 32'd0);
      check("rst out_byte",  {24'h0, out_byte},  32'd0);
      check("rst out_last",  {31'h0, out_last},  32'd0);
      check("rst err",       {31'h0, err},       32'd0);
      @(posedge clk);
      #1;

      // 16 literals, no stalls
      ready_mode = 0;
      for (int i = 0; i < 16; i++) send_item(1'b0, 8'(8'h41 + i), 12'h0, 4'h0, 1'b0);
      drain();
      add_exp(8'h00, 1'b0);
      add_exp(8'h00, 1'b0);
      for (int i = 0; i < 16; i++) add_exp(8'(8'h41 + i), 1'b0);
      check_got("s_lit16");

      // Copy then closing literal
      send_item(1'b1, 8'h00, 12'h123, 4'd4, 1'b0);
      send_item(1'b0, 8'h5A, 12'h000, 4'd0, 1'b1);
      drain();
      add_exp(8'h01, 1'b0); add_exp(8'h00, 1'b0);
      add_exp(8'h14, 1'b0); add_exp(8'h23, 1'b0); add_exp(8'h5A, 1'b1);
      check_got("s_copy_lit");

      // Full group of maximal copies
      for (int i = 0; i < 16; i++) send_item(1'b1, 8'h00, 12'hFFF, 4'd15, 1'b0);
      drain();
      for (int i = 0; i < 34; i++) add_exp(8'hFF, 1'b0);
      check_got("s_copy16");

      // Stall in CTRL_HI with the next item already waiting
      for (int i = 0; i < 8; i++) send_item(1'b0, 8'(8'h10 + i), 12'h0, 4'h0, 1'b0);
      send_item(1'b1, 8'h00, 12'h2AB, 4'd5, 1'b1);
      ready_script = '{1'b1, 1'b0, 1'b0, 1'b1};
      send_item(1'b0, 8'h77, 12'h000, 4'd0, 1'b1);
      drain();
      add_exp(8'h00, 1'b0); add_exp(8'h01, 1'b0);
      for (int i = 0; i < 8; i++) add_exp(8'(8'h10 + i), 1'b0);
      add_exp(8'h25, 1'b0); add_exp(8'hAB, 1'b1);
      add_exp(8'h00, 1'b0); add_exp(8'h00, 1'b0); add_exp(8'h77, 1'b1);
      check_got("s_stall");

      // Illegal copy length: flagged, packed, sticky
      send_item(1'b1, 8'h00, 12'h005, 4'd1, 1'b1);
      drain();
      check("illegal err", {31'h0, err}, 32'd1);
      add_exp(8'h01, 1'b0); add_exp(8'h00, 1'b0);
      add_exp(8'h01, 1'b0); add_exp(8'h05, 1'b1);
      check_got("s_illegal");
      send_item(1'b0, 8'h3C, 12'h000, 4'd0, 1'b1);
      drain();
      check("sticky err", {31'h0, err}, 32'd1);
      got_q.delete();

      // Reset after 5 body bytes
      for (int i = 0; i < 16; i++) send_item(1'b0, 8'(8'h61 + i), 12'h0, 4'h0, 1'b0);
      n = 0;
      while (got_q.size() < 7 && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (got_q.size() < 7) fail_now("wait body5");
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(4);
      check("post-reset err", {31'h0, err}, 32'd0);
      add_exp(8'h00, 1'b0); add_exp(8'h00, 1'b0);
      for (int i = 0; i < 5; i++) add_exp(8'(8'h61 + i), 1'b0);
      check_got("s_reset_mid");
      send_item(1'b0, 8'h99, 12'h000, 4'd0, 1'b1);
      drain();
      add_exp(8'h00, 1'b0); add_exp(8'h00, 1'b0); add_exp(8'h99, 1'b1);
      check_got("s_after_reset");

      // Randomized run against the model
      ready_mode = 1;
      for (int i = 0; i < 400; i++) begin
         cp  = ($urandom_range(0, 9) < 4);
         lit = 8'($urandom);
         off = ($urandom_range(0, 19) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
         len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
         lst = ($urandom_range(0, 9) == 0) || (i == 200) || (i == 399);
         send_item(cp, lit, off, len, lst);
         if (i == 200) begin
            idle(3);
            reset = 1'b1;
            idle(2);
            reset = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            idle($urandom_range(1, 3));
         end
      end
      drain();
      got_q.delete();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
